// File: rtl/fir_l2_output_packer.sv
// fir_l2_output_packer
// Output stage of the L=2 FIR: each cycle it may receive an even/odd sample
// pair at full accumulator precision. It rounds and saturates both samples to
// audio width, writes them into a small FIFO as two entries (even first), and
// drains the FIFO one sample per cycle over a valid/ready stream.
// A pair is written whole or dropped whole, so the output stream never loses
// one half of a pair. Dropping sets a sticky overflow flag.

module fir_l2_output_packer #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int SHIFT          = 30,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic [DATA_IN_WIDTH-1:0]        data_in_1,
  input  logic [DATA_IN_WIDTH-1:0]        data_in_2,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_OUT_WIDTH-1:0]       out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            sat_pulse,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Rounding constant: one half of the LSB that survives the shift.
  localparam logic signed [DATA_IN_WIDTH:0] RND =
    (DATA_IN_WIDTH+1)'(1) << (SHIFT - 1);

  // Saturation limits, held at the widened working width so they compare
  // directly against the shifted value.
  localparam logic signed [DATA_IN_WIDTH:0] SAT_MAX =
    (DATA_IN_WIDTH+1)'((1 << (DATA_OUT_WIDTH - 1)) - 1);
  localparam logic signed [DATA_IN_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

  // Result of rounding one sample: narrowed value plus a clip indication.
  typedef struct packed {
    logic                      clip;
    logic [DATA_OUT_WIDTH-1:0] y;
  } rs_t;

  // Round half toward +inf, then clamp to the signed output range.
  // The add happens one bit wider than the input so it can never wrap.
  function automatic rs_t round_sat(input logic [DATA_IN_WIDTH-1:0] x);
    logic signed [DATA_IN_WIDTH:0] t;
    logic signed [DATA_IN_WIDTH:0] r;
    rs_t                           res;
    t        = $signed({x[DATA_IN_WIDTH-1], x}) + RND;
    r        = t >>> SHIFT;
    res.clip = 1'b1;
    if (r > SAT_MAX) begin
      res.y = SAT_MAX[DATA_OUT_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      res.y = SAT_MIN[DATA_OUT_WIDTH-1:0];
    end else begin
      res.y    = r[DATA_OUT_WIDTH-1:0];
      res.clip = 1'b0;
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: round/saturate and register the pair
  // ---------------------------------------------------------------------
  rs_t rs_1;
  rs_t rs_2;

  assign rs_1 = round_sat(data_in_1);
  assign rs_2 = round_sat(data_in_2);

  logic                      pipe_valid_q;
  logic [DATA_OUT_WIDTH-1:0] y1_q;
  logic [DATA_OUT_WIDTH-1:0] y2_q;
  logic                      sat_q;

  // Stage-1 pipeline register: rounded pair, its valid bit and the clip pulse.
  // NOTE: state is updated with <= so every flop samples the pre-edge values;
  // a blocking = here would let later statements see already-updated state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid_q <= 1'b0;
      y1_q         <= '0;
      y2_q         <= '0;
      sat_q        <= 1'b0;
    end else begin
      pipe_valid_q <= in_valid;
      y1_q         <= rs_1.y;
      y2_q         <= rs_2.y;
      sat_q        <= in_valid & (rs_1.clip | rs_2.clip);
    end
  end

  assign sat_pulse = sat_q;

  // ---------------------------------------------------------------------
  // Stage 2: FIFO of single samples, written two at a time
  // ---------------------------------------------------------------------
  logic [DATA_OUT_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] fifo_level_q, fifo_level_d;
  logic             overflow_q, overflow_d;

  logic             rd_fire;
  logic             wr_fire;
  logic             room_ok;
  logic [LVL_W:0]   level_after;
  logic [PTR_W-1:0] wr_ptr_nx;

  assign out_valid = (fifo_level_q != '0);
  assign rd_fire   = out_valid & out_ready;
  assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);

  // Admission decision and next-state for pointers, level and overflow flag.
  // A head transfer on the same edge frees one slot for the incoming pair.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    level_after  = '0;
    room_ok      = 1'b0;
    wr_fire      = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_level_d = fifo_level_q;
    overflow_d   = overflow_q;

    level_after = {1'b0, fifo_level_q} + (LVL_W+1)'(2) - (LVL_W+1)'(rd_fire);
    room_ok     = (level_after <= (LVL_W+1)'(FIFO_DEPTH));
    wr_fire     = pipe_valid_q & room_ok;

    if (pipe_valid_q && !room_ok) begin
      overflow_d = 1'b1;
    end
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(2);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fifo_level_d = fifo_level_q
                 + (wr_fire ? LVL_W'(2) : LVL_W'(0))
                 - LVL_W'(rd_fire);
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_level_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_level_q <= fifo_level_d;
      overflow_q   <= overflow_d;
    end
  end

  // Sample storage: the even sample lands at the write pointer, the odd one
  // right after it (wrapping naturally with the pointer width).
  // NOTE: the array has no reset; its contents are only observable through
  // entries the level counter marks as written, and the output is forced to
  // zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q]  <= y1_q;
      mem[wr_ptr_nx] <= y2_q;
    end
  end

  assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = fifo_level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_l2_output_packer.sv
// tb_fir_l2_output_packer
// Directed scenarios followed by randomized traffic. Every cycle the outputs
// are compared against a queue-based reference model that applies the
// rounding/saturation rule arithmetically and the whole-pair admission rule
// to a sample queue.

module tb_fir_l2_output_packer;

  localparam int IW    = 64;
  localparam int OW    = 16;
  localparam int SHIFT = 30;
  localparam int DEPTH = 8;

  logic                        clk;
  logic                        reset_n;
  logic                        in_valid;
  logic [IW-1:0]               data_in_1;
  logic [IW-1:0]               data_in_2;
  logic                        out_ready;
  logic                        out_valid;
  logic [OW-1:0]               out_data;
  logic [$clog2(DEPTH):0]      fifo_level;
  logic                        sat_pulse;
  logic                        overflow;

  fir_l2_output_packer #(
    .DATA_IN_WIDTH (IW),
    .DATA_OUT_WIDTH(OW),
    .SHIFT         (SHIFT),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fifo_level(fifo_level),
    .sat_pulse (sat_pulse),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  longint q[$];
  bit     pend_v;
  longint pend_1, pend_2;
  bit     ovf_m;
  bit     sat_m;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rounded value = floor(x / 2^SHIFT) plus one when the first dropped
  // fraction bit is set (fraction >= 1/2), then clamped to the output range.
  function automatic longint ref_sample(input longint x, output bit clip);
    longint r;
    longint hi;
    longint lo;
    hi   = (longint'(1) <<< (OW - 1)) - 1;
    lo   = -(longint'(1) <<< (OW - 1));
    r    = (x >>> SHIFT) + ((x >>> (SHIFT - 1)) & 1);
    clip = 1'b0;
    if (r > hi) begin r = hi; clip = 1'b1; end
    if (r < lo) begin r = lo; clip = 1'b1; end
    return r;
  endfunction

  function automatic longint rand_x();
    longint k;
    case ($urandom_range(0, 3))
      0:       return {$urandom(), $urandom()};
      1:       return longint'($signed($urandom())) <<< 15;
      2:       return longint'($signed($urandom())) >>> 1;
      default: begin
        k = longint'($urandom_range(0, 80000)) - 40000;
        return (k <<< SHIFT) + (longint'($urandom_range(0, 3)) <<< (SHIFT - 2));
      end
    endcase
  endfunction

  task automatic drive(input bit v, input longint a, input longint b, input bit rdy);
    in_valid  = v;
    data_in_1 = a;
    data_in_2 = b;
    out_ready = rdy;
  endtask

  task automatic model_clear();
    q.delete();
    pend_v = 1'b0;
    ovf_m  = 1'b0;
    sat_m  = 1'b0;
  endtask

  // Advance one clock: update the model for this edge from the current
  // inputs, then compare every output at the following falling edge.
  task automatic tick();
    bit     rd;
    bit     c1, c2;
    int     sz;
    longint y1, y2;
    sz = q.size();
    rd = (sz != 0) && out_ready;
    if (rd) void'(q.pop_front());
    if (pend_v) begin
      if (sz - int'(rd) + 2 <= DEPTH) begin
        q.push_back(pend_1);
        q.push_back(pend_2);
      end else begin
        ovf_m = 1'b1;
      end
    end
    y1     = ref_sample(longint'(data_in_1), c1);
    y2     = ref_sample(longint'(data_in_2), c2);
    sat_m  = in_valid && (c1 || c2);
    pend_v = in_valid;
    pend_1 = y1;
    pend_2 = y2;
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, q.size() != 0);
    check("fifo_level", fifo_level, q.size());
    check("sat_pulse", sat_pulse, sat_m);
    check("overflow", overflow, ovf_m);
    if (q.size() != 0) check("out_data", $signed(out_data), q[0]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_sat"}, sat_pulse, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check_all_zero("reset");
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    model_clear();
    #1;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Passthrough: 5 then -3 on consecutive cycles, visible two edges later
    drive(1, 5 <<< 30, -(3 <<< 30), 1);
    tick();
    check("pt_not_yet", out_valid, 0);
    drive(0, 0, 0, 1);
    tick();
    check("pt_first", $signed(out_data), 5);
    check("pt_valid", out_valid, 1);
    tick();
    check("pt_second", $signed(out_data), -3);
    tick();

    // Rounding: 1.5 -> 2, -1.5 -> -1, just below half -> 0
    drive(1, 64'h6000_0000, -(3 <<< 29), 1);
    tick();
    drive(1, (1 <<< 29) - 1, 0, 1);
    tick();
    check("rnd_pos_half", $signed(out_data), 2);
    drive(0, 0, 0, 1);
    tick();
    check("rnd_neg_half", $signed(out_data), -1);
    tick();
    check("rnd_below_half", $signed(out_data), 0);
    tick();
    tick();

    // Saturation: single-cycle pulse, clamped extremes; in-range pair no pulse
    drive(1, 40000 <<< 30, -(40000 <<< 30), 1);
    tick();
    check("sat_pulse_on", sat_pulse, 1);
    drive(1, 7 <<< 30, 8 <<< 30, 1);
    tick();
    check("sat_pulse_off", sat_pulse, 0);
    check("sat_max", $signed(out_data), 32767);
    drive(0, 0, 0, 1);
    tick();
    check("sat_min", $signed(out_data), -32768);
    check("sat_in_range_pulse", sat_pulse, 0);
    repeat (4) tick();

    // Backpressure: five pairs with out_ready low, fifth must be dropped
    for (int k = 1; k <= 5; k++) begin
      drive(1, longint'(2 * k - 1) <<< 30, longint'(2 * k) <<< 30, 0);
      tick();
      drive(0, 0, 0, 0);
      tick();
    end
    check("bp_level_full", fifo_level, 8);
    check("bp_overflow", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      check("bp_drain", $signed(out_data), i);
      drive(0, 0, 0, 1);
      tick();
    end
    check("bp_level_empty", fifo_level, 0);
    check("bp_overflow_sticky", overflow, 1);

    // Boundary: level 7 with a head transfer on the write edge accepts the pair
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, longint'(k) <<< 30, -(longint'(k) <<< 30), 0);
      tick();
      drive(0, 0, 0, 0);
      tick();
    end
    drive(1, 11 <<< 30, 12 <<< 30, 1);
    tick();
    check("bd_level7", fifo_level, 7);
    drive(0, 0, 0, 1);
    tick();
    check("bd_accept_level", fifo_level, 8);
    check("bd_accept_ovf", overflow, 0);
    drive(0, 0, 0, 1);
    tick();
    drive(1, 13 <<< 30, 14 <<< 30, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    check("bd_drop_level", fifo_level, 7);
    check("bd_drop_ovf", overflow, 1);
    repeat (9) begin
      drive(0, 0, 0, 1);
      tick();
    end

    // Randomized traffic with a reset asserted in the middle of it
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        drive(1, rand_x(), rand_x(), 1);
        tick();
        do_reset();
        repeat (3) begin
          drive(0, rand_x(), rand_x(), $urandom_range(0, 1) == 1);
          tick();
        end
        check("post_reset_idle", out_valid, 0);
      end
      drive($urandom_range(0, 2) == 0, rand_x(), rand_x(),
            $urandom_range(0, 3) != 0);
      tick();
    end
    repeat (12) begin
      drive(0, 0, 0, 1);
      tick();
    end
    check("final_empty", fifo_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
